// File: rtl/spi_reg_bank.sv
// Register bank behind an SPI slave: ID/CTRL/STATUS/SCRATCH registers plus a
// sample FIFO that the DSP pushes into and the SPI master drains via FIFO_DATA.
module spi_reg_bank #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic                            addr_ready,
  input  logic                            rw,
  input  logic [DATA_WIDTH-1:0]           data_out,
  input  logic                            data_ready,
  output logic [DATA_WIDTH-1:0]           data_in,
  input  logic [DATA_WIDTH-1:0]           sample_data,
  input  logic                            sample_valid,
  output logic [DATA_WIDTH-1:0]           ctrl,
  output logic                            wr_strobe,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [ADDR_WIDTH-1:0] {
    REG_ID        = ADDR_WIDTH'(8'h00),
    REG_CTRL      = ADDR_WIDTH'(8'h01),
    REG_STATUS    = ADDR_WIDTH'(8'h02),
    REG_FIFO_DATA = ADDR_WIDTH'(8'h03),
    REG_SCRATCH   = ADDR_WIDTH'(8'h04)
  } reg_addr_e;

  localparam logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(24'h564E41);

  // Edge detection and transaction context
  logic                  addr_ready_q;
  logic                  data_ready_q;
  logic                  addr_evt;
  logic                  data_evt;
  logic                  lat_valid;
  logic                  lat_rw;
  logic [ADDR_WIDTH-1:0] lat_addr;

  // Register storage
  logic [DATA_WIDTH-1:0] scratch;

  // FIFO
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  rd_req;
  logic                  pop;
  logic                  push;
  logic                  ovf_set;
  logic                  ovf_clr;
  logic                  wr_ok;

  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rd_value;

  assign addr_evt = addr_ready & ~addr_ready_q;
  assign data_evt = data_ready & ~data_ready_q;

  assign empty = (fifo_count == '0);
  assign full  = (fifo_count == CNT_W'(FIFO_DEPTH));

  // A read of FIFO_DATA frees a slot in the same cycle, so a push into a
  // full FIFO is still accepted when it coincides with a pop.
  assign rd_req  = addr_evt & rw;
  assign pop     = rd_req & (addr == REG_FIFO_DATA) & ~empty;
  assign push    = sample_valid & (~full | pop);
  assign ovf_set = sample_valid & full & ~pop;
  assign ovf_clr = rd_req & (addr == REG_STATUS);

  assign wr_ok = data_evt & lat_valid & ~lat_rw &
                 ((lat_addr == REG_CTRL) | (lat_addr == REG_SCRATCH));

  // NOTE: every variable in an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    status    = '0;
    status[4:0] = 5'(fifo_count);
    status[5] = overflow;
    status[6] = empty;
  end

  always_comb begin
    rd_value = '0;
    case (addr)
      REG_ID:        rd_value = ID_VALUE;
      REG_CTRL:      rd_value = ctrl;
      REG_STATUS:    rd_value = status;
      REG_FIFO_DATA: if (!empty) rd_value = mem[rd_ptr];
      REG_SCRATCH:   rd_value = scratch;
      default:       rd_value = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      lat_valid    <= 1'b0;
      lat_rw       <= 1'b0;
      lat_addr     <= '0;
      data_in      <= '0;
    end else begin
      addr_ready_q <= addr_ready;
      data_ready_q <= data_ready;
      if (addr_evt) begin
        lat_valid <= 1'b1;
        lat_rw    <= rw;
        lat_addr  <= addr;
        data_in   <= rd_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= '0;
      scratch   <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_strobe <= wr_ok;
      if (wr_ok) begin
        wr_addr <= lat_addr;
        if (lat_addr == REG_CTRL) ctrl    <= data_out;
        else                      scratch <= data_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      // Set wins over clear so a sample dropped during a STATUS read is not lost.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // NOTE: storage array is deliberately not reset; the pointers and count
  // define which entries are valid, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_data;
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: vector table for register/FIFO basics plus
// hand-written sequences for overflow, coincident push/pop and reset abort.
module tb_spi_reg_bank;

  logic        clk;
  logic        rst;
  logic [6:0]  addr;
  logic        addr_ready;
  logic        rw;
  logic [23:0] data_out;
  logic        data_ready;
  logic [23:0] data_in;
  logic [23:0] sample_data;
  logic        sample_valid;
  logic [23:0] ctrl;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [4:0]  fifo_count;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  spi_reg_bank #(.ADDR_WIDTH(7), .DATA_WIDTH(24), .FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .addr_ready   (addr_ready),
    .rw           (rw),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .data_in      (data_in),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .ctrl         (ctrl),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_PUSH} op_e;

  typedef struct {
    op_e         op;
    logic [6:0]  a;
    logic [23:0] d;
    logic [23:0] exp_data;
    logic        exp_strobe;
    logic [6:0]  exp_wr_addr;
    logic [23:0] exp_ctrl;
    logic [4:0]  exp_count;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [6:0] a, output logic [23:0] d, output logic [4:0] c);
    addr = a; rw = 1'b1; addr_ready = 1'b1;
    tick();
    d = data_in;
    c = fifo_count;
    addr_ready = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [6:0] a, input logic [23:0] d,
                          output logic s, output logic [6:0] wa,
                          output logic [23:0] cq, output logic s_after);
    addr = a; rw = 1'b0; addr_ready = 1'b1;
    tick();
    data_out = d; data_ready = 1'b1;
    tick();
    s = wr_strobe; wa = wr_addr; cq = ctrl;
    data_ready = 1'b0; addr_ready = 1'b0;
    tick();
    s_after = wr_strobe;
  endtask

  task automatic do_push(input logic [23:0] d);
    sample_data = d; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  logic [23:0] rd;
  logic [4:0]  cnt;
  logic        s, s_after;
  logic [6:0]  wa;
  logic [23:0] cq;

  initial begin
    vecs[0]  = '{OP_RD,   7'h00, 24'h0,      24'h564E41, 1'b0, 7'h00, 24'h0,      5'd0};
    vecs[1]  = '{OP_WR,   7'h01, 24'hA5A5A5, 24'h0,      1'b1, 7'h01, 24'hA5A5A5, 5'd0};
    vecs[2]  = '{OP_RD,   7'h01, 24'h0,      24'hA5A5A5, 1'b0, 7'h00, 24'h0,      5'd0};
    vecs[3]  = '{OP_WR,   7'h04, 24'h00BEEF, 24'h0,      1'b1, 7'h04, 24'hA5A5A5, 5'd0};
    vecs[4]  = '{OP_RD,   7'h04, 24'h0,      24'h00BEEF, 1'b0, 7'h00, 24'h0,      5'd0};
    vecs[5]  = '{OP_WR,   7'h00, 24'h123456, 24'h0,      1'b0, 7'h04, 24'hA5A5A5, 5'd0};
    vecs[6]  = '{OP_RD,   7'h00, 24'h0,      24'h564E41, 1'b0, 7'h00, 24'h0,      5'd0};
    vecs[7]  = '{OP_WR,   7'h02, 24'h111111, 24'h0,      1'b0, 7'h04, 24'hA5A5A5, 5'd0};
    vecs[8]  = '{OP_WR,   7'h05, 24'h222222, 24'h0,      1'b0, 7'h04, 24'hA5A5A5, 5'd0};
    vecs[9]  = '{OP_RD,   7'h05, 24'h0,      24'h000000, 1'b0, 7'h00, 24'h0,      5'd0};
    vecs[10] = '{OP_RD,   7'h7F, 24'h0,      24'h000000, 1'b0, 7'h00, 24'h0,      5'd0};
    vecs[11] = '{OP_RD,   7'h02, 24'h0,      24'h000040, 1'b0, 7'h00, 24'h0,      5'd0};
    vecs[12] = '{OP_PUSH, 7'h00, 24'h000001, 24'h0,      1'b0, 7'h00, 24'h0,      5'd1};
    vecs[13] = '{OP_PUSH, 7'h00, 24'h000002, 24'h0,      1'b0, 7'h00, 24'h0,      5'd2};
    vecs[14] = '{OP_PUSH, 7'h00, 24'h000003, 24'h0,      1'b0, 7'h00, 24'h0,      5'd3};
    vecs[15] = '{OP_RD,   7'h02, 24'h0,      24'h000003, 1'b0, 7'h00, 24'h0,      5'd3};
    vecs[16] = '{OP_RD,   7'h03, 24'h0,      24'h000001, 1'b0, 7'h00, 24'h0,      5'd2};
    vecs[17] = '{OP_RD,   7'h03, 24'h0,      24'h000002, 1'b0, 7'h00, 24'h0,      5'd1};
    vecs[18] = '{OP_RD,   7'h03, 24'h0,      24'h000003, 1'b0, 7'h00, 24'h0,      5'd0};
    vecs[19] = '{OP_RD,   7'h03, 24'h0,      24'h000000, 1'b0, 7'h00, 24'h0,      5'd0};
    vecs[20] = '{OP_RD,   7'h01, 24'h0,      24'hA5A5A5, 1'b0, 7'h00, 24'h0,      5'd0};
    vecs[21] = '{OP_RD,   7'h02, 24'h0,      24'h000040, 1'b0, 7'h00, 24'h0,      5'd0};

    rst = 1'b1; addr = '0; addr_ready = 1'b0; rw = 1'b0;
    data_out = '0; data_ready = 1'b0; sample_data = '0; sample_valid = 1'b0;
    tick();
    tick();
    check("rst_data_in",    data_in,    0);
    check("rst_ctrl",       ctrl,       0);
    check("rst_wr_strobe",  wr_strobe,  0);
    check("rst_wr_addr",    wr_addr,    0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow",   overflow,   0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 22; i++) begin
      case (vecs[i].op)
        OP_RD: begin
          do_read(vecs[i].a, rd, cnt);
          check($sformatf("vec%0d_rd_data", i), rd, vecs[i].exp_data);
          check($sformatf("vec%0d_rd_count", i), cnt, vecs[i].exp_count);
        end
        OP_WR: begin
          do_write(vecs[i].a, vecs[i].d, s, wa, cq, s_after);
          check($sformatf("vec%0d_wr_strobe", i), s, vecs[i].exp_strobe);
          check($sformatf("vec%0d_wr_addr", i), wa, vecs[i].exp_wr_addr);
          check($sformatf("vec%0d_ctrl", i), cq, vecs[i].exp_ctrl);
          check($sformatf("vec%0d_strobe_drop", i), s_after, 0);
        end
        default: begin
          do_push(vecs[i].d);
          check($sformatf("vec%0d_push_count", i), fifo_count, vecs[i].exp_count);
        end
      endcase
    end

    // Fill to capacity, then one more sample overflows and is dropped.
    for (int i = 0; i < 16; i++) do_push(24'h100 + 24'(i));
    check("full_count",     fifo_count, 16);
    check("full_no_ovf",    overflow,   0);
    do_push(24'h110);
    check("ovf_count",      fifo_count, 16);
    check("ovf_set",        overflow,   1);
    do_read(7'h02, rd, cnt);
    check("ovf_status",     rd,         24'h000030);
    check("ovf_cleared",    overflow,   0);

    // Full FIFO: FIFO_DATA read coincident with a push.
    addr = 7'h03; rw = 1'b1; addr_ready = 1'b1;
    sample_data = 24'hABCDEF; sample_valid = 1'b1;
    tick();
    check("fullpp_data",  data_in,    24'h000100);
    check("fullpp_count", fifo_count, 16);
    check("fullpp_ovf",   overflow,   0);
    addr_ready = 1'b0; sample_valid = 1'b0;
    tick();
    for (int i = 1; i < 16; i++) begin
      do_read(7'h03, rd, cnt);
      check($sformatf("drain%0d_data", i), rd, 24'h100 + 24'(i));
      check($sformatf("drain%0d_count", i), cnt, 16 - i);
    end
    do_read(7'h03, rd, cnt);
    check("drain_last_data",  rd,  24'hABCDEF);
    check("drain_last_count", cnt, 0);

    // Empty FIFO: pop request coincident with a push returns 0, keeps the push.
    addr = 7'h03; rw = 1'b1; addr_ready = 1'b1;
    sample_data = 24'h000777; sample_valid = 1'b1;
    tick();
    check("emptypp_data",  data_in,    0);
    check("emptypp_count", fifo_count, 1);
    addr_ready = 1'b0; sample_valid = 1'b0;
    tick();
    do_read(7'h03, rd, cnt);
    check("emptypp_pop_data",  rd,  24'h000777);
    check("emptypp_pop_count", cnt, 0);

    // Overflow set on the same cycle as a STATUS read: set wins.
    for (int i = 0; i < 16; i++) do_push(24'h200 + 24'(i));
    addr = 7'h02; rw = 1'b1; addr_ready = 1'b1;
    sample_data = 24'h000999; sample_valid = 1'b1;
    tick();
    check("setclr_status", data_in,    24'h000010);
    check("setclr_ovf",    overflow,   1);
    check("setclr_count",  fifo_count, 16);
    addr_ready = 1'b0; sample_valid = 1'b0;
    tick();

    // Address events with rw = 0 must neither clear overflow nor pop.
    addr = 7'h02; rw = 1'b0; addr_ready = 1'b1;
    tick();
    addr_ready = 1'b0;
    tick();
    check("wr_evt_no_clear", overflow, 1);
    addr = 7'h03; rw = 1'b0; addr_ready = 1'b1;
    tick();
    addr_ready = 1'b0;
    tick();
    check("wr_evt_no_pop", fifo_count, 16);
    do_read(7'h02, rd, cnt);
    check("status_after_wr_evt", rd,       24'h000030);
    check("ovf_clear_again",     overflow, 0);

    // Reset between address and data phases abandons the write.
    addr = 7'h01; rw = 1'b0; addr_ready = 1'b1;
    tick();
    rst = 1'b1; addr_ready = 1'b0;
    tick();
    check("midrst_data_in",    data_in,    0);
    check("midrst_ctrl",       ctrl,       0);
    check("midrst_fifo_count", fifo_count, 0);
    check("midrst_overflow",   overflow,   0);
    check("midrst_wr_addr",    wr_addr,    0);
    rst = 1'b0;
    tick();
    data_out = 24'h5A5A5A; data_ready = 1'b1;
    tick();
    check("abort_no_strobe", wr_strobe, 0);
    check("abort_ctrl",      ctrl,      0);
    data_ready = 1'b0;
    tick();
    do_read(7'h04, rd, cnt);
    check("abort_scratch_reset", rd, 0);
    do_read(7'h01, rd, cnt);
    check("abort_ctrl_read",     rd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, meaning the SPI register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 24, meaning the SPI payload width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16 (power of two), meaning the sample FIFO entry count.
REQ-004 SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port addr  input  ADDR_WIDTH  register address from the SPI slave.
REQ-007 SHALL have port addr_ready  input  1  address valid level from the SPI slave.
REQ-008 SHALL have port rw  input  1  transfer direction, 1 = read, 0 = write.
REQ-009 SHALL have port data_out  input  DATA_WIDTH  write payload from the SPI slave.
REQ-010 SHALL have port data_ready  input  1  payload valid level from the SPI slave.
REQ-011 SHALL have port data_in  output  DATA_WIDTH  registered read data returned to the SPI slave.
REQ-012 SHALL have port sample_data  input  DATA_WIDTH  DSP result word.
REQ-013 SHALL have port sample_valid  input  1  one-cycle push strobe for sample_data.
REQ-014 SHALL have port ctrl  output  DATA_WIDTH  contents of the CTRL register.
REQ-015 SHALL have port wr_strobe  output  1  one-cycle pulse after each accepted register write.
REQ-016 SHALL have port wr_addr  output  ADDR_WIDTH  address of the last accepted write.
REQ-017 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-018 SHALL have port overflow  output  1  sticky FIFO overflow flag.

Function
REQ-019 SHALL use this register map: 0x00 ID (read-only, 0x564E41); 0x01 CTRL (read/write); 0x02 STATUS (read-only); 0x03 FIFO_DATA (read-only, pop on read); 0x04 SCRATCH (read/write).
REQ-020 SHALL lay out STATUS as [4:0] fifo_count, [5] overflow, [6] empty, with all other bits 0.
REQ-021 SHALL return 0 for reads of any unmapped address and SHALL ignore writes to unmapped or read-only addresses (no wr_strobe).
REQ-022 SHALL detect the address event as addr_ready = 1 while its value registered in the previous cycle was 0 (single-cycle rising edge).
REQ-023 SHALL, on the address event, register the selected read value into data_in one clk later and hold it until the next address event.
REQ-024 SHALL, on an address event with rw = 1 and addr = 0x03 and FIFO not empty, load data_in with the FIFO head and pop exactly one entry.
REQ-025 SHALL, on an address event with rw = 1 and addr = 0x03 and FIFO empty, load data_in with 0 and perform no pop.
REQ-026 SHALL, on an address event with rw = 1 and addr = 0x02, load data_in with the pre-clear STATUS value and clear overflow in the same cycle.
REQ-027 SHALL NOT pop the FIFO or clear overflow on address events with rw = 0.
REQ-028 SHALL latch addr and rw on the address event for use by the subsequent write.
REQ-029 SHALL, on a data_ready rising edge with latched rw = 0 and a writable latched address, write data_out into that register and pulse wr_strobe for 1 clk, with wr_addr updated in the same cycle.
REQ-030 SHALL push sample_data when sample_valid = 1 and the FIFO is not full; count = FIFO_DEPTH marks full.
REQ-031 SHALL, when sample_valid = 1 and the FIFO is full with no simultaneous pop, drop the sample, set overflow, and leave count unchanged.
REQ-032 SHALL, on a simultaneous push and pop, accept both and leave count unchanged, including when the FIFO is full (no overflow).
REQ-033 SHALL, on a simultaneous push and pop with the FIFO empty, accept only the push (count becomes 1) and return data_in = 0.
REQ-034 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-035 SHALL give overflow set priority over clear when both occur in the same cycle.

Reset
REQ-036 SHALL, while rst = 1, drive data_in = 0, ctrl = 0, SCRATCH = 0, wr_strobe = 0, wr_addr = 0, fifo_count = 0, overflow = 0, empty the FIFO, and clear edge history and latched rw/addr.
REQ-037 SHALL, when rst is asserted mid-transaction, abandon the transaction so that any later data_ready edge without a new address event causes no write.

Verification
REQ-038 SHALL pass: read addr 0x00 -> data_in = 0x564E41 one clk after the addr_ready rise.
REQ-039 SHALL pass: write 0x01 with 0xA5A5A5 -> ctrl = 0xA5A5A5, one wr_strobe pulse, wr_addr = 0x01; a following read of 0x01 returns 0xA5A5A5.
REQ-040 SHALL pass: push 3 samples (1, 2, 3), then read 0x03 four times -> data_in = 1, 2, 3, 0 and fifo_count goes 3, 2, 1, 0, 0.
REQ-041 SHALL pass: push 17 samples -> fifo_count = 16, overflow = 1; read 0x02 -> data_in = 0x000030, after which overflow = 0.
REQ-042 SHALL pass: with the FIFO full, a FIFO_DATA read coincident with sample_valid -> count stays 16, overflow stays 0, and data_in = oldest sample.
REQ-043 SHALL pass: write 0x00 with 0x123456 -> no wr_strobe and a read of 0x00 still returns 0x564E41; rst asserted between addr_ready and data_ready -> no write occurs.
